alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered issue stage between instruction decode and the execute-stage ALU. It translates RV32 opcode/funct fields into the 4-bit ALU control code and selects the A/B operands. It also drives the ALU inputs from a 2-entry skid buffer with valid/ready handshakes on both sides. It produces the ALU's control encoding and flags encodings the ALU cannot execute.

## Interface
- Parameters: none.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode stage presents an instruction.
- in_ready  out  1  stage can accept; registered (no combinational path from out_ready).
- opcode  in  7  instruction[6:0].
- funct3  in  3  instruction[14:12].
- funct7  in  7  instruction[31:25].
- rs1_data  in  32  register operand 1.
- rs2_data  in  32  register operand 2.
- imm  in  32  sign-extended immediate from decode.
- rd  in  5  destination register, passed through.
- flush  in  1  synchronous kill of all buffered entries.
- out_valid  out  1  A/B/ALUControl valid for execute.
- out_ready  in  1  execute consumes this cycle.
- A  out  32  ALU operand A.
- B  out  32  ALU operand B.
- ALUControl  out  4  ALU function code.
- out_rd  out  5  rd of the presented entry.
- illegal  out  1  entry's encoding is not executable.

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0100, SLT 1000, SLL 0011, SRL 0101, MUL 0110, XOR 0111.
- R-type, opcode 0110011, A=rs1_data, B=rs2_data:
  - f3 000: f7 0000000 → ADD; f7 0100000 → SUB.
  - f3 001, f7 0 → SLL.
  - f3 010, f7 0 → SLT.
  - f3 100, f7 0 → XOR.
  - f3 101, f7 0 → SRL.
  - f3 110, f7 0 → OR.
  - f3 111, f7 0 → AND.
- I-type ALU, opcode 0010011, A=rs1_data, B=imm:
  - f3 000 → ADD; 010 → SLT; 100 → XOR; 110 → OR; 111 → AND.
  - f3 001, f7 0 → SLL.
  - f3 101, f7 0 → SRL.
- Shifts, R- and I-type: B = {27'b0, operand[4:0]}, because the ALU shifts by the full B value.
- Load 0000011 and store 0100011: ADD, A=rs1_data, B=imm.
- Branch 1100011: SUB, A=rs1_data, B=rs2_data, for Zero-based compare.
- Every other encoding → illegal=1, ALUControl=0010, A=0, B=0. This includes SLTU, SRA, SRAI, bad funct7 values and unknown opcodes.
- Illegal entries still flow through the handshake; execute owns the trap.
- Buffer has two entries: output register plus skid register.
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - in_ready = !skid_full.
  - If output is empty or draining, accepted entry goes to the output register. Otherwise it goes to skid.
  - When output drains and skid is full, skid moves to output and in_ready rises next cycle.
  - Order is strictly FIFO.
- Output fields hold stable while out_valid & !out_ready.

## Timing
- Reset values: out_valid=0, in_ready=1, A=0, B=0, ALUControl=0010, out_rd=0, illegal=0, skid empty.
- Reset applied mid-operation discards both entries immediately, without waiting for a clock edge.
- Latency: accept at edge N → out_valid at edge N. Decode is combinational ahead of the register.
- Throughput is 1/cycle with out_ready held high.
- Backpressure: with out_ready low, at most two entries are accepted. in_ready drops the cycle after the skid fills.
- Simultaneous accept and drain with output full and skid empty: new entry goes to output; skid stays empty.
- flush: at the next edge, out_valid=0, skid is emptied and in_ready=1.
  - Any input offered in the flush cycle is dropped.
  - flush dominates out_ready.

## Configuration
- ALU_MUL_EN defined: R-type f3 000 / f7 0000001 → MUL (0110), A=rs1_data, B=rs2_data, illegal=0.
- ALU_MUL_EN undefined: that encoding decodes as illegal=1, ALUControl=0010, A=B=0.
- The macro changes no other behaviour or timing.

## Test plan
- Reset, then `add` (rs1=5, rs2=3) with out_ready=1 → next cycle out_valid=1, A=5, B=3, ALUControl=0010, illegal=0.
- `slli` with imm=0xFFFFFFE3, then `sub` → first output has ALUControl=0011, B=0x00000003. Second output has ALUControl=0100, in order, back-to-back.
- out_ready=0, then push three instructions → two accepted, in_ready=0 for the third. Raising out_ready delivers entries 1 then 2, and in_ready returns to 1.
- `sra` (f3 101, f7 0100000) and opcode 0x7F → illegal=1, A=0, B=0, ALUControl=0010.
- MUL encoding → with ALU_MUL_EN: ALUControl=0110, illegal=0. Without: illegal=1.
- Two entries buffered, then flush=1 with in_valid=1 → next cycle out_valid=0 and in_ready=1. The flushed entries and the offered entry never appear.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage: RV32 opcode/funct decode to 4-bit ALU control, operand select, 2-entry skid buffer.
// Optional macro ALU_MUL_EN enables decode of R-type MUL (f3 000 / f7 0000001).
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ALUControl,
    output logic [4:0]  out_rd,
    output logic        illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_MUL = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [31:0] dec_a, dec_b, b_src;
    logic [3:0]  dec_ctl, ctl_raw;
    logic        dec_ill, ill_raw, is_shift, f7_zero;

    assign f7_zero = (funct7 == 7'b0000000);

    always_comb begin
        ctl_raw  = ALU_ADD;
        ill_raw  = 1'b0;
        is_shift = 1'b0;
        b_src    = rs2_data;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        if (f7_zero)                    ctl_raw = ALU_ADD;
                        else if (funct7 == 7'b0100000)  ctl_raw = ALU_SUB;
`ifdef ALU_MUL_EN
                        else if (funct7 == 7'b0000001)  ctl_raw = ALU_MUL;
`endif
                        else                            ill_raw = 1'b1;
                    end
                    3'b001: begin ctl_raw = ALU_SLL; is_shift = 1'b1; ill_raw = !f7_zero; end
                    3'b010: begin ctl_raw = ALU_SLT; ill_raw = !f7_zero; end
                    3'b100: begin ctl_raw = ALU_XOR; ill_raw = !f7_zero; end
                    3'b101: begin ctl_raw = ALU_SRL; is_shift = 1'b1; ill_raw = !f7_zero; end
                    3'b110: begin ctl_raw = ALU_OR;  ill_raw = !f7_zero; end
                    3'b111: begin ctl_raw = ALU_AND; ill_raw = !f7_zero; end
                    default: ill_raw = 1'b1;
                endcase
            end
            OP_I: begin
                b_src = imm;
                case (funct3)
                    3'b000: ctl_raw = ALU_ADD;
                    3'b010: ctl_raw = ALU_SLT;
                    3'b100: ctl_raw = ALU_XOR;
                    3'b110: ctl_raw = ALU_OR;
                    3'b111: ctl_raw = ALU_AND;
                    3'b001: begin ctl_raw = ALU_SLL; is_shift = 1'b1; ill_raw = !f7_zero; end
                    3'b101: begin ctl_raw = ALU_SRL; is_shift = 1'b1; ill_raw = !f7_zero; end
                    default: ill_raw = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                ctl_raw = ALU_ADD;
                b_src   = imm;
            end
            OP_BRANCH: ctl_raw = ALU_SUB;
            default:   ill_raw = 1'b1;
        endcase
    end

    // The ALU shifts by the whole B value, so only the shamt bits may survive.
    always_comb begin
        dec_ill = ill_raw;
        dec_ctl = ill_raw ? ALU_ADD : ctl_raw;
        dec_a   = ill_raw ? '0 : rs1_data;
        dec_b   = ill_raw ? '0 : (is_shift ? {27'b0, b_src[4:0]} : b_src);
    end

    logic        skid_valid;
    logic [31:0] skid_a, skid_b;
    logic [3:0]  skid_ctl;
    logic [4:0]  skid_rd;
    logic        skid_ill;
    logic        accept, out_free;

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready && !flush;
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            A          <= '0;
            B          <= '0;
            ALUControl <= ALU_ADD;
            out_rd     <= '0;
            illegal    <= 1'b0;
            skid_valid <= 1'b0;
            skid_a     <= '0;
            skid_b     <= '0;
            skid_ctl   <= ALU_ADD;
            skid_rd    <= '0;
            skid_ill   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            // Skid is older than anything offered now (in_ready is low while it is full).
            if (skid_valid) begin
                out_valid  <= 1'b1;
                A          <= skid_a;
                B          <= skid_b;
                ALUControl <= skid_ctl;
                out_rd     <= skid_rd;
                illegal    <= skid_ill;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                A          <= dec_a;
                B          <= dec_b;
                ALUControl <= dec_ctl;
                out_rd     <= rd;
                illegal    <= dec_ill;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_a     <= dec_a;
            skid_b     <= dec_b;
            skid_ctl   <= dec_ctl;
            skid_rd    <= rd;
            skid_ill   <= dec_ill;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: mnemonic-level reference model, queue of expected outputs.
module tb_alu_issue_stage;

    logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready, illegal;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, imm, A, B;
    logic [4:0]  rd, out_rd;
    logic [3:0]  ALUControl;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .out_rd(out_rd), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;

    string r_names[8] = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
    string i_names[8] = '{"addi", "slli", "slti", "sltiu", "xori", "srli", "ori", "andi"};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [31:0] im, input logic [4:0] d);
        exp_t  e;
        string mn;
        logic  use_imm, legal;
        logic [3:0] code;
        mn = "bad";
        use_imm = 1'b0;
        if (op == 7'h33) begin
            mn = r_names[f3];
            if (f7 == 7'h20 && f3 == 3'd0)      mn = "sub";
            else if (f7 == 7'h20 && f3 == 3'd5) mn = "sra";
            else if (f7 == 7'h01 && f3 == 3'd0) mn = "mul";
            else if (f7 != 7'h00)               mn = "bad";
        end else if (op == 7'h13) begin
            use_imm = 1'b1;
            mn = i_names[f3];
            if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) mn = "bad";
        end else if (op == 7'h03) begin
            mn = "lw"; use_imm = 1'b1;
        end else if (op == 7'h23) begin
            mn = "sw"; use_imm = 1'b1;
        end else if (op == 7'h63) begin
            mn = "beq";
        end
        legal = 1'b1;
        code  = 4'd2;
        if (mn == "add" || mn == "addi" || mn == "lw" || mn == "sw") code = 4'd2;
        else if (mn == "sub" || mn == "beq")  code = 4'd4;
        else if (mn == "and" || mn == "andi") code = 4'd0;
        else if (mn == "or"  || mn == "ori")  code = 4'd1;
        else if (mn == "xor" || mn == "xori") code = 4'd7;
        else if (mn == "slt" || mn == "slti") code = 4'd8;
        else if (mn == "sll" || mn == "slli") code = 4'd3;
        else if (mn == "srl" || mn == "srli") code = 4'd5;
`ifdef ALU_MUL_EN
        else if (mn == "mul") code = 4'd6;
`endif
        else legal = 1'b0;
        e.rd  = d;
        e.ill = !legal;
        if (legal) begin
            e.ctl = code;
            e.a   = r1;
            e.b   = use_imm ? im : r2;
            if (code == 4'd3 || code == 4'd5) e.b = e.b % 32;
        end else begin
            e.ctl = 4'd2;
            e.a   = 32'd0;
            e.b   = 32'd0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else if (mon_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    chk("A", A, e.a);
                    chk("B", B, e.b);
                    chk("ALUControl", {28'd0, ALUControl}, {28'd0, e.ctl});
                    chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
                end
                if (in_valid && in_ready)
                    q.push_back(model(opcode, funct3, funct7, rs1_data, rs2_data, imm, rd));
            end
        end
    end

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [4:0] d, input logic ordy, input logic fl);
        in_valid = v; opcode = op; funct3 = f3; funct7 = f7;
        rs1_data = r1; rs2_data = r2; imm = im; rd = d;
        out_ready = ordy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 7'h33, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0, ordy, 1'b0);
    endtask

    logic [6:0] ops[6] = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
    logic [6:0] f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h00};

    initial begin
        logic [6:0] op, f7;
        rst = 1'b1;
        drive(1'b0, 7'h33, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_A", A, 32'd0);
        chk("rst_B", B, 32'd0);
        chk("rst_ALUControl", {28'd0, ALUControl}, 32'd2);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(1'b1, 2);

        // add rs1=5 rs2=3
        drive(1'b1, 7'h33, 3'd0, 7'h00, 32'd5, 32'd3, 32'd0, 5'd1, 1'b1, 1'b0);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_A", A, 32'd5);
        chk("add_B", B, 32'd3);
        chk("add_ctl", {28'd0, ALUControl}, 32'd2);
        chk("add_ill", {31'd0, illegal}, 32'd0);

        // slli imm=0xFFFFFFE3 then sub, back-to-back
        drive(1'b1, 7'h13, 3'd1, 7'h00, 32'd7, 32'd0, 32'hFFFFFFE3, 5'd2, 1'b1, 1'b0);
        chk("slli_ctl", {28'd0, ALUControl}, 32'd3);
        chk("slli_B", B, 32'd3);
        drive(1'b1, 7'h33, 3'd0, 7'h20, 32'd9, 32'd4, 32'd0, 5'd3, 1'b1, 1'b0);
        chk("sub_ctl", {28'd0, ALUControl}, 32'd4);
        chk("sub_rd", {27'd0, out_rd}, 32'd3);
        idle(1'b1, 2);

        // backpressure: three offers, two accepted
        drive(1'b1, 7'h33, 3'd4, 7'h00, 32'd11, 32'd12, 32'd0, 5'd4, 1'b0, 1'b0);
        drive(1'b1, 7'h33, 3'd6, 7'h00, 32'd21, 32'd22, 32'd0, 5'd5, 1'b0, 1'b0);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 7'h33, 3'd7, 7'h00, 32'd31, 32'd32, 32'd0, 5'd6, 1'b0, 1'b0);
        chk("bp_out_rd_held", {27'd0, out_rd}, 32'd4);
        idle(1'b1, 3);
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);

        // illegal encodings: sra and opcode 0x7F
        drive(1'b1, 7'h33, 3'd5, 7'h20, 32'd8, 32'd2, 32'd0, 5'd7, 1'b1, 1'b0);
        chk("sra_ill", {31'd0, illegal}, 32'd1);
        chk("sra_A", A, 32'd0);
        chk("sra_ctl", {28'd0, ALUControl}, 32'd2);
        drive(1'b1, 7'h7F, 3'd0, 7'h00, 32'd8, 32'd2, 32'd5, 5'd8, 1'b1, 1'b0);
        chk("op7f_ill", {31'd0, illegal}, 32'd1);
        chk("op7f_B", B, 32'd0);

        // MUL encoding
        drive(1'b1, 7'h33, 3'd0, 7'h01, 32'd6, 32'd7, 32'd0, 5'd9, 1'b1, 1'b0);
`ifdef ALU_MUL_EN
        chk("mul_ctl", {28'd0, ALUControl}, 32'd6);
        chk("mul_ill", {31'd0, illegal}, 32'd0);
`else
        chk("mul_ctl", {28'd0, ALUControl}, 32'd2);
        chk("mul_ill", {31'd0, illegal}, 32'd1);
`endif
        idle(1'b1, 2);

        // flush with two buffered entries and an offered one
        drive(1'b1, 7'h13, 3'd0, 7'h00, 32'd1, 32'd0, 32'd100, 5'd10, 1'b0, 1'b0);
        drive(1'b1, 7'h13, 3'd4, 7'h00, 32'd2, 32'd0, 32'd200, 5'd11, 1'b0, 1'b0);
        drive(1'b1, 7'h13, 3'd6, 7'h00, 32'd3, 32'd0, 32'd300, 5'd12, 1'b1, 1'b1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        idle(1'b1, 3);

        // asynchronous reset mid-operation
        drive(1'b1, 7'h33, 3'd0, 7'h00, 32'd1, 32'd2, 32'd0, 5'd13, 1'b0, 1'b0);
        drive(1'b1, 7'h33, 3'd1, 7'h00, 32'd3, 32'd4, 32'd0, 5'd14, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_A", A, 32'd0);
        chk("arst_ctl", {28'd0, ALUControl}, 32'd2);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1'b1, 2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
            f7 = ($urandom_range(0, 7) == 0) ? 7'($urandom) : f7s[$urandom_range(0, 3)];
            drive($urandom_range(0, 3) != 0, op, 3'($urandom), f7, $urandom, $urandom, $urandom,
                  5'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
        idle(1'b1, 4);
        chk("final_empty", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
